// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter with per-grant outstanding-request tracking.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority (master 0).
module wb_arbiter2 #(
    parameter int ADDRESS_WIDTH   = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wbm0_cyc,
    input  logic                      i_wbm0_stb,
    input  logic                      i_wbm0_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_wbm0_adr,
    input  logic [DATA_WIDTH-1:0]     i_wbm0_dat,
    input  logic [DATA_WIDTH/8-1:0]   i_wbm0_sel,
    output logic                      o_wbm0_stall,
    output logic                      o_wbm0_ack,
    output logic [DATA_WIDTH-1:0]     o_wbm0_dat,
    input  logic                      i_wbm1_cyc,
    input  logic                      i_wbm1_stb,
    input  logic                      i_wbm1_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_wbm1_adr,
    input  logic [DATA_WIDTH-1:0]     i_wbm1_dat,
    input  logic [DATA_WIDTH/8-1:0]   i_wbm1_sel,
    output logic                      o_wbm1_stall,
    output logic                      o_wbm1_ack,
    output logic [DATA_WIDTH-1:0]     o_wbm1_dat,
    output logic                      o_wbs_cyc,
    output logic                      o_wbs_stb,
    output logic                      o_wbs_we,
    output logic [ADDRESS_WIDTH-1:0]  o_wbs_adr,
    output logic [DATA_WIDTH-1:0]     o_wbs_dat,
    output logic [DATA_WIDTH/8-1:0]   o_wbs_sel,
    input  logic                      i_wbs_stall,
    input  logic                      i_wbs_ack,
    input  logic [DATA_WIDTH-1:0]     i_wbs_dat,
    output logic [1:0]                o_grant
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_grant;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_g0;
    logic                   w_g1;
    logic                   w_stall;
    logic                   w_ack;
    logic                   w_accept;
    logic                   w_tie_m0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // r_last = 1 means master 1 held the most recent grant, so master 0 wins the next tie.
    logic                   r_last;
    assign w_tie_m0 = r_last;
`else
    assign w_tie_m0 = 1'b1;
`endif

    assign w_g0     = (r_state == GRANT0);
    assign w_g1     = (r_state == GRANT1);
    assign w_stall  = i_wbs_stall | (r_cnt == CNT_MAX);
    assign w_ack    = i_wbs_ack & (r_cnt != '0);
    assign w_accept = o_wbs_stb & ~w_stall;

    assign o_wbs_cyc = (w_g0 & i_wbm0_cyc) | (w_g1 & i_wbm1_cyc);
    assign o_wbs_stb = (w_g0 & i_wbm0_stb) | (w_g1 & i_wbm1_stb);
    assign o_wbs_we  = w_g1 ? i_wbm1_we  : i_wbm0_we;
    assign o_wbs_adr = w_g1 ? i_wbm1_adr : i_wbm0_adr;
    assign o_wbs_dat = w_g1 ? i_wbm1_dat : i_wbm0_dat;
    assign o_wbs_sel = w_g1 ? i_wbm1_sel : i_wbm0_sel;

    assign o_wbm0_stall = w_g0 ? w_stall : 1'b1;
    assign o_wbm1_stall = w_g1 ? w_stall : 1'b1;
    assign o_wbm0_ack   = w_g0 & w_ack;
    assign o_wbm1_ack   = w_g1 & w_ack;
    assign o_wbm0_dat   = i_wbs_dat;
    assign o_wbm1_dat   = i_wbs_dat;
    assign o_grant      = r_grant;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && !w_ack) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_accept && w_ack) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Dropping cyc aborts the grant's outstanding requests, so the counter is cleared on every exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_cnt   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (i_wbm0_cyc && (!i_wbm1_cyc || w_tie_m0)) begin
                        r_state <= GRANT0;
                        r_grant <= 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        r_last  <= 1'b0;
`endif
                    end else if (i_wbm1_cyc) begin
                        r_state <= GRANT1;
                        r_grant <= 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        r_last  <= 1'b1;
`endif
                    end
                end
                GRANT0: begin
                    if (!i_wbm0_cyc) begin
                        r_cnt <= '0;
                        if (i_wbm1_cyc) begin
                            r_state <= GRANT1;
                            r_grant <= 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
                            r_last  <= 1'b1;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                GRANT1: begin
                    if (!i_wbm1_cyc) begin
                        r_cnt <= '0;
                        if (i_wbm0_cyc) begin
                            r_state <= GRANT0;
                            r_grant <= 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
                            r_last  <= 1'b0;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (MAX_OUTSTANDING=2); the slave is driven directly by the bench.
module tb_wb_arbiter2;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_wbm0_cyc, i_wbm0_stb, i_wbm0_we;
    logic [9:0]  i_wbm0_adr;
    logic [31:0] i_wbm0_dat;
    logic [3:0]  i_wbm0_sel;
    logic        o_wbm0_stall, o_wbm0_ack;
    logic [31:0] o_wbm0_dat;
    logic        i_wbm1_cyc, i_wbm1_stb, i_wbm1_we;
    logic [9:0]  i_wbm1_adr;
    logic [31:0] i_wbm1_dat;
    logic [3:0]  i_wbm1_sel;
    logic        o_wbm1_stall, o_wbm1_ack;
    logic [31:0] o_wbm1_dat;
    logic        o_wbs_cyc, o_wbs_stb, o_wbs_we;
    logic [9:0]  o_wbs_adr;
    logic [31:0] o_wbs_dat;
    logic [3:0]  o_wbs_sel;
    logic        i_wbs_stall, i_wbs_ack;
    logic [31:0] i_wbs_dat;
    logic [1:0]  o_grant;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter2 #(
        .ADDRESS_WIDTH  (10),
        .DATA_WIDTH     (32),
        .MAX_OUTSTANDING(2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wbm0_cyc  (i_wbm0_cyc),
        .i_wbm0_stb  (i_wbm0_stb),
        .i_wbm0_we   (i_wbm0_we),
        .i_wbm0_adr  (i_wbm0_adr),
        .i_wbm0_dat  (i_wbm0_dat),
        .i_wbm0_sel  (i_wbm0_sel),
        .o_wbm0_stall(o_wbm0_stall),
        .o_wbm0_ack  (o_wbm0_ack),
        .o_wbm0_dat  (o_wbm0_dat),
        .i_wbm1_cyc  (i_wbm1_cyc),
        .i_wbm1_stb  (i_wbm1_stb),
        .i_wbm1_we   (i_wbm1_we),
        .i_wbm1_adr  (i_wbm1_adr),
        .i_wbm1_dat  (i_wbm1_dat),
        .i_wbm1_sel  (i_wbm1_sel),
        .o_wbm1_stall(o_wbm1_stall),
        .o_wbm1_ack  (o_wbm1_ack),
        .o_wbm1_dat  (o_wbm1_dat),
        .o_wbs_cyc   (o_wbs_cyc),
        .o_wbs_stb   (o_wbs_stb),
        .o_wbs_we    (o_wbs_we),
        .o_wbs_adr   (o_wbs_adr),
        .o_wbs_dat   (o_wbs_dat),
        .o_wbs_sel   (o_wbs_sel),
        .i_wbs_stall (i_wbs_stall),
        .i_wbs_ack   (i_wbs_ack),
        .i_wbs_dat   (i_wbs_dat),
        .o_grant     (o_grant)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow a further 1ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_wbm0_cyc = 1'b0; i_wbm0_stb = 1'b0; i_wbm0_we = 1'b0;
        i_wbm0_adr = '0;   i_wbm0_dat = '0;   i_wbm0_sel = 4'hF;
        i_wbm1_cyc = 1'b0; i_wbm1_stb = 1'b0; i_wbm1_we = 1'b0;
        i_wbm1_adr = '0;   i_wbm1_dat = '0;   i_wbm1_sel = 4'hF;
        i_wbs_stall = 1'b0; i_wbs_ack = 1'b0; i_wbs_dat = '0;

        // Reset state
        #2;
        chk2("rst_grant", o_grant, 2'b00);
        chk1("rst_wbs_cyc", o_wbs_cyc, 1'b0);
        chk1("rst_wbs_stb", o_wbs_stb, 1'b0);
        chk1("rst_m0_stall", o_wbm0_stall, 1'b1);
        chk1("rst_m1_stall", o_wbm1_stall, 1'b1);
        chk1("rst_m0_ack", o_wbm0_ack, 1'b0);
        chk1("rst_m1_ack", o_wbm1_ack, 1'b0);
        #6 i_rst_n = 1'b1;
        tick();

        // Single master read
        i_wbm0_cyc = 1'b1; i_wbm0_stb = 1'b1; i_wbm0_adr = 10'h000;
        #1;
        chk2("rd_grant_pre", o_grant, 2'b00);
        chk1("rd_m0_stall_pre", o_wbm0_stall, 1'b1);
        chk1("rd_wbs_cyc_pre", o_wbs_cyc, 1'b0);
        tick();
        #1;
        chk2("rd_grant", o_grant, 2'b01);
        chk1("rd_wbs_cyc", o_wbs_cyc, 1'b1);
        chk1("rd_wbs_stb", o_wbs_stb, 1'b1);
        chk1("rd_m0_stall", o_wbm0_stall, 1'b0);
        chk1("rd_m1_stall", o_wbm1_stall, 1'b1);
        tick();
        i_wbm0_stb = 1'b0; i_wbs_ack = 1'b1; i_wbs_dat = 32'hDEADBEEF;
        #1;
        chk1("rd_m0_ack", o_wbm0_ack, 1'b1);
        chk32("rd_m0_dat", o_wbm0_dat, 32'hDEADBEEF);
        chk1("rd_m1_ack", o_wbm1_ack, 1'b0);
        chk1("rd_m1_stall_ack", o_wbm1_stall, 1'b1);
        tick();
        #1;
        chk1("rd_m0_ack_once", o_wbm0_ack, 1'b0);
        i_wbs_ack = 1'b0; i_wbm0_cyc = 1'b0;
        tick();
        #1;
        chk2("rd_grant_idle", o_grant, 2'b00);

        // Tie after reset and direct handover
        i_wbm0_cyc = 1'b1; i_wbm1_cyc = 1'b1;
        tick();
        #1;
        chk2("tie1_grant", o_grant, 2'b01);
        i_wbm0_cyc = 1'b0;
        tick();
        #1;
        chk2("tie1_handover", o_grant, 2'b10);
        i_wbm1_cyc = 1'b0;
        tick();
        #1;
        chk2("tie1_idle", o_grant, 2'b00);
        i_wbm0_cyc = 1'b1; i_wbm1_cyc = 1'b1;
        tick();
        #1;
        chk2("tie2_grant", o_grant, 2'b01);
        i_wbm0_cyc = 1'b0; i_wbm1_cyc = 1'b0;
        tick();
        i_wbm0_cyc = 1'b1; i_wbm1_cyc = 1'b1;
        tick();
        #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
        chk2("tie3_grant", o_grant, 2'b10);
`else
        chk2("tie3_grant", o_grant, 2'b01);
`endif
        i_wbm0_cyc = 1'b0; i_wbm1_cyc = 1'b0;
        tick();
        #1;
        chk2("tie3_idle", o_grant, 2'b00);

        // Outstanding limit of 2 with a silent slave
        i_wbm0_cyc = 1'b1; i_wbm0_stb = 1'b1; i_wbm0_adr = 10'h004;
        tick();
        #1;
        chk1("lim_req1_stall", o_wbm0_stall, 1'b0);
        tick();
        #1;
        chk1("lim_req2_stall", o_wbm0_stall, 1'b0);
        tick();
        #1;
        chk1("lim_full_stall", o_wbm0_stall, 1'b1);
        tick();
        #1;
        chk1("lim_full_stall2", o_wbm0_stall, 1'b1);
        i_wbs_ack = 1'b1; i_wbs_dat = 32'h0000_0011;
        #1;
        chk1("lim_ack1", o_wbm0_ack, 1'b1);
        chk32("lim_ack1_dat", o_wbm0_dat, 32'h0000_0011);
        tick();
        i_wbs_ack = 1'b0;
        #1;
        chk1("lim_slot_free", o_wbm0_stall, 1'b0);
        tick();
        #1;
        chk1("lim_full_again", o_wbm0_stall, 1'b1);
        i_wbs_ack = 1'b1; i_wbs_dat = 32'h0000_0022;
        #1;
        chk1("lim_ack2", o_wbm0_ack, 1'b1);
        chk32("lim_ack2_dat", o_wbm0_dat, 32'h0000_0022);
        tick();
        i_wbs_ack = 1'b0;
        #1;
        chk1("lim_slot_free2", o_wbm0_stall, 1'b0);
        tick();
        i_wbm0_stb = 1'b0; i_wbs_ack = 1'b1; i_wbs_dat = 32'h0000_0033;
        #1;
        chk1("lim_ack3", o_wbm0_ack, 1'b1);
        chk32("lim_ack3_dat", o_wbm0_dat, 32'h0000_0033);
        tick();
        i_wbs_dat = 32'h0000_0044;
        #1;
        chk1("lim_ack4", o_wbm0_ack, 1'b1);
        chk32("lim_ack4_dat", o_wbm0_dat, 32'h0000_0044);
        tick();
        #1;
        chk1("lim_no_ack5", o_wbm0_ack, 1'b0);
        i_wbs_ack = 1'b0; i_wbm0_cyc = 1'b0;
        tick();

        // Simultaneous accept and ack from master 1
        i_wbm1_cyc = 1'b1; i_wbm1_stb = 1'b1; i_wbm1_adr = 10'h008;
        tick();
        #1;
        chk2("sim_grant", o_grant, 2'b10);
        chk1("sim_m1_stall", o_wbm1_stall, 1'b0);
        chk32("sim_wbs_adr", 32'(o_wbs_adr), 32'h0000_0008);
        chk1("sim_m0_stall", o_wbm0_stall, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            i_wbs_ack = 1'b1; i_wbs_dat = 32'hABCD0000 + 32'(i);
            #1;
            chk1("sim_m1_ack", o_wbm1_ack, 1'b1);
            chk32("sim_m1_dat", o_wbm1_dat, 32'hABCD0000 + 32'(i));
            chk1("sim_m0_ack", o_wbm0_ack, 1'b0);
            chk1("sim_cnt_le1", o_wbm1_stall, 1'b0);
            tick();
        end
        i_wbm1_stb = 1'b0; i_wbs_dat = 32'hABCD0004;
        #1;
        chk1("sim_m1_ack5", o_wbm1_ack, 1'b1);
        chk32("sim_m1_dat5", o_wbm1_dat, 32'hABCD0004);
        chk1("sim_m0_ack5", o_wbm0_ack, 1'b0);
        tick();
        i_wbs_ack = 1'b0;

        // Abort with one outstanding, then a late ack
        i_wbm1_stb = 1'b1;
        tick();
        i_wbm1_stb = 1'b0; i_wbm1_cyc = 1'b0;
        tick();
        i_wbs_ack = 1'b1; i_wbs_dat = 32'h1234_5678;
        #1;
        chk1("abt_m0_ack", o_wbm0_ack, 1'b0);
        chk1("abt_m1_ack", o_wbm1_ack, 1'b0);
        chk2("abt_grant", o_grant, 2'b00);
        i_wbs_ack = 1'b0; i_wbm1_cyc = 1'b1;
        tick();
        i_wbs_ack = 1'b1;
        #1;
        chk2("abt_regrant", o_grant, 2'b10);
        chk1("abt_cnt_zero", o_wbm1_ack, 1'b0);
        chk1("abt_stall", o_wbm1_stall, 1'b0);
        i_wbs_ack = 1'b0;

        // Asynchronous reset mid-burst
        i_wbm1_stb = 1'b1;
        tick();
        #1;
        chk1("ar_wbs_cyc_pre", o_wbs_cyc, 1'b1);
        #1 i_rst_n = 1'b0;
        #1;
        chk1("ar_wbs_cyc", o_wbs_cyc, 1'b0);
        chk1("ar_wbs_stb", o_wbs_stb, 1'b0);
        chk2("ar_grant", o_grant, 2'b00);
        chk1("ar_m0_stall", o_wbm0_stall, 1'b1);
        chk1("ar_m1_stall", o_wbm1_stall, 1'b1);
        #1 i_rst_n = 1'b1;
        i_wbm1_stb = 1'b0;
        tick();
        i_wbs_ack = 1'b1;
        #1;
        chk2("ar_regrant", o_grant, 2'b10);
        chk1("ar_ack_dropped", o_wbm1_ack, 1'b0);
        i_wbs_ack = 1'b0; i_wbm1_cyc = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
